// File: rtl/sine_period_meter_if.sv
// Sample stream in, period/extrema measurement out.
// Signal names match the meter's external ports.
interface sine_period_meter_if #(
  parameter int N     = 7,
  parameter int CNT_W = 16
);
  logic [N:0]       sample_in;
  logic             sample_en;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic [N:0]       peak;
  logic [N:0]       trough;
  logic             locked;
  logic             overflow;

  modport master (
    output sample_in,
    output sample_en,
    input  period,
    input  period_valid,
    input  peak,
    input  trough,
    input  locked,
    input  overflow
  );

  modport slave (
    input  sample_in,
    input  sample_en,
    output period,
    output period_valid,
    output peak,
    output trough,
    output locked,
    output overflow
  );
endinterface

// File: rtl/sine_period_meter.sv
// Measures a sine period between hysteresis-qualified rising crossings.
// Also reports the peak and trough seen over that period.
module sine_period_meter #(
  parameter int N     = 7,
  parameter int CNT_W = 16,
  parameter int HYST  = 8
) (
  input logic clk,
  input logic reset,
  sine_period_meter_if.slave bus
);
  localparam int MID = 1 << N;
  localparam logic [N:0] TH_HI = (N+1)'(MID + HYST);
  localparam logic [N:0] TH_LO = (N+1)'(MID - HYST);
  localparam logic [CNT_W-1:0] CNT_PRE = ~CNT_W'(1);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    LOW    = 2'd1,
    HIGH   = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] period_q;
  logic [N:0]       pk;
  logic [N:0]       tr;
  logic [N:0]       peak_q;
  logic [N:0]       trough_q;
  logic             armed;
  logic             valid_q;
  logic             locked_q;
  logic             ovf_q;

  logic below;
  logic above;
  logic rc;
  logic sat;

  assign below = bus.sample_in < TH_LO;
  assign above = bus.sample_in >= TH_HI;

  always_comb begin
    state_nx = state;
    rc       = 1'b0;
    sat      = 1'b0;
    if (bus.sample_en) begin
      unique case (state)
        SEARCH: begin
          if (below) state_nx = LOW;
        end
        LOW: begin
          // a crossing wins over counter saturation
          if (above) begin
            state_nx = HIGH;
            rc       = 1'b1;
          end else if (cnt == CNT_PRE) begin
            state_nx = SEARCH;
            sat      = 1'b1;
          end
        end
        HIGH: begin
          if (cnt == CNT_PRE) begin
            state_nx = SEARCH;
            sat      = 1'b1;
          end else if (below) begin
            state_nx = LOW;
          end
        end
        default: state_nx = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= SEARCH;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt      <= '0;
      period_q <= '0;
      pk       <= '0;
      tr       <= '1;
      peak_q   <= '0;
      trough_q <= '1;
      armed    <= 1'b0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (bus.sample_en) begin
        unique case (1'b1)
          sat: begin
            cnt      <= '0;
            armed    <= 1'b0;
            locked_q <= 1'b0;
            ovf_q    <= 1'b1;
          end
          rc: begin
            cnt   <= CNT_W'(1);
            pk    <= bus.sample_in;
            tr    <= bus.sample_in;
            armed <= 1'b1;
            // the first crossing after SEARCH only opens the window
            if (armed) begin
              period_q <= cnt;
              peak_q   <= pk;
              trough_q <= tr;
              valid_q  <= 1'b1;
              locked_q <= 1'b1;
            end
          end
          (state == SEARCH): begin
            if (below) begin
              pk <= bus.sample_in;
              tr <= bus.sample_in;
            end
          end
          default: begin
            cnt <= cnt + 1'b1;
            if (bus.sample_in > pk) pk <= bus.sample_in;
            if (bus.sample_in < tr) tr <= bus.sample_in;
          end
        endcase
      end
    end
  end

  assign bus.period       = period_q;
  assign bus.period_valid = valid_q;
  assign bus.peak         = peak_q;
  assign bus.trough       = trough_q;
  assign bus.locked       = locked_q;
  assign bus.overflow     = ovf_q;
endmodule

// File: tb/tb_sine_period_meter.sv
// Directed bench for sine_period_meter.
// u1: default parameters; u2: CNT_W = 8 for saturation.
module tb_sine_period_meter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sine_period_meter_if #(.N(7), .CNT_W(16)) b1 ();
  sine_period_meter_if #(.N(7), .CNT_W(8))  b2 ();

  sine_period_meter #(.N(7), .CNT_W(16), .HYST(8)) u1 (
    .clk(clk), .reset(reset), .bus(b1)
  );
  sine_period_meter #(.N(7), .CNT_W(8), .HYST(8)) u2 (
    .clk(clk), .reset(reset), .bus(b2)
  );

  function automatic logic [7:0] sine(input int i);
    real v;
    v = 127.5 + 127.5 * $sin(6.283185307179586 * (i % 256) / 256.0) + 0.5;
    if (v > 255.0) v = 255.0;
    if (v < 0.0) v = 0.0;
    return 8'($rtoi(v));
  endfunction

  task automatic step1(input logic [7:0] s, input logic en);
    b1.sample_in = s;
    b1.sample_en = en;
    @(posedge clk);
    #1;
  endtask

  task automatic step2(input logic [7:0] s, input logic en);
    b2.sample_in = s;
    b2.sample_en = en;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    b1.sample_in = 8'd0;
    b1.sample_en = 1'b1;
    b2.sample_in = 8'd0;
    b2.sample_en = 1'b1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++; if (b1.period !== 16'd0) begin n_bad++; $display("FAIL rst_period: got %0d want 0", b1.period); end
    n_cmp++; if (b1.peak !== 8'd0) begin n_bad++; $display("FAIL rst_peak: got %0d want 0", b1.peak); end
    n_cmp++; if (b1.trough !== 8'hff) begin n_bad++; $display("FAIL rst_trough: got %0d want 255", b1.trough); end
    n_cmp++; if (b1.period_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %0b want 0", b1.period_valid); end
    n_cmp++; if (b1.locked !== 1'b0) begin n_bad++; $display("FAIL rst_locked: got %0b want 0", b1.locked); end
    n_cmp++; if (b1.overflow !== 1'b0) begin n_bad++; $display("FAIL rst_ovf: got %0b want 0", b1.overflow); end
    n_cmp++; if (b2.period !== 8'd0 || b2.trough !== 8'hff) begin n_bad++; $display("FAIL rst_u2: got period %0d trough %0d want 0 255", b2.period, b2.trough); end
    reset = 1'b1;
    b2.sample_en = 1'b0;
  endtask

  task automatic test_sweep();
    int npv = 0;
    int first = -1;
    pulse_reset();
    for (int i = 0; i < 1040; i++) begin
      step1(sine(i), 1'b1);
      if (i == 300) begin
        n_cmp++; if (b1.locked !== 1'b0) begin n_bad++; $display("FAIL sweep_unlocked: got %0b want 0", b1.locked); end
      end
      if (i == 600) begin
        n_cmp++; if (b1.period !== 16'd256) begin n_bad++; $display("FAIL sweep_hold: got %0d want 256", b1.period); end
      end
      if (b1.period_valid) begin
        npv++;
        if (first < 0) first = i;
        n_cmp++;
        if (b1.period !== 16'd256 || b1.peak !== 8'd255 || b1.trough !== 8'd0 || b1.locked !== 1'b1)
          begin n_bad++; $display("FAIL sweep_pulse: got p%0d pk%0d tr%0d lk%0b want 256 255 0 1", b1.period, b1.peak, b1.trough, b1.locked); end
      end
    end
    n_cmp++; if (first !== 515) begin n_bad++; $display("FAIL sweep_first: got %0d want 515", first); end
    n_cmp++; if (npv !== 3) begin n_bad++; $display("FAIL sweep_count: got %0d want 3", npv); end
  endtask

  task automatic test_noise();
    int npv = 0;
    pulse_reset();
    for (int i = 0; i < 1000; i++) begin
      step1((i % 2 == 0) ? 8'd124 : 8'd132, 1'b1);
      if (b1.period_valid) npv++;
    end
    n_cmp++; if (npv !== 0) begin n_bad++; $display("FAIL noise_valid: got %0d want 0", npv); end
    n_cmp++; if (u1.state !== 2'd0) begin n_bad++; $display("FAIL noise_state: got %0d want 0", u1.state); end
    n_cmp++; if (b1.locked !== 1'b0) begin n_bad++; $display("FAIL noise_locked: got %0b want 0", b1.locked); end
  endtask

  task automatic test_strobe();
    int npv = 0;
    int last = -1;
    pulse_reset();
    for (int c = 0; c < 3 * 1040; c++) begin
      step1(sine(c / 3), (c % 3) == 0);
      if (b1.period_valid) begin
        npv++;
        if (last < 0) begin
          n_cmp++; if (c !== 1545) begin n_bad++; $display("FAIL strobe_first: got %0d want 1545", c); end
        end else begin
          n_cmp++; if (c - last !== 768) begin n_bad++; $display("FAIL strobe_gap: got %0d want 768", c - last); end
        end
        n_cmp++; if (b1.period !== 16'd256) begin n_bad++; $display("FAIL strobe_period: got %0d want 256", b1.period); end
        last = c;
      end
    end
    n_cmp++; if (npv !== 3) begin n_bad++; $display("FAIL strobe_count: got %0d want 3", npv); end
  endtask

  task automatic test_overflow();
    int npv = 0;
    b1.sample_en = 1'b0;
    pulse_reset();
    step2(8'd0, 1'b1);
    step2(8'd255, 1'b1);
    step2(8'd0, 1'b1);
    step2(8'd255, 1'b1);
    n_cmp++; if (b2.period_valid !== 1'b1 || b2.period !== 8'd2 || b2.locked !== 1'b1)
      begin n_bad++; $display("FAIL ovf_lock: got v%0b p%0d lk%0b want 1 2 1", b2.period_valid, b2.period, b2.locked); end
    for (int i = 0; i < 253; i++) begin
      step2(8'd0, 1'b1);
      if (b2.period_valid) npv++;
    end
    n_cmp++; if (b2.overflow !== 1'b0 || b2.locked !== 1'b1)
      begin n_bad++; $display("FAIL ovf_early: got ovf%0b lk%0b want 0 1", b2.overflow, b2.locked); end
    step2(8'd0, 1'b1);
    if (b2.period_valid) npv++;
    n_cmp++; if (b2.overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set: got %0b want 1", b2.overflow); end
    n_cmp++; if (b2.locked !== 1'b0) begin n_bad++; $display("FAIL ovf_unlock: got %0b want 0", b2.locked); end
    n_cmp++; if (u2.state !== 2'd0) begin n_bad++; $display("FAIL ovf_state: got %0d want 0", u2.state); end
    n_cmp++; if (npv !== 0 || b2.period !== 8'd2) begin n_bad++; $display("FAIL ovf_novalid: got n%0d p%0d want 0 2", npv, b2.period); end
    step2(8'd0, 1'b1);
    step2(8'd255, 1'b1);
    n_cmp++; if (b2.period_valid !== 1'b0) begin n_bad++; $display("FAIL ovf_rearm: got %0b want 0", b2.period_valid); end
    step2(8'd0, 1'b1);
    step2(8'd255, 1'b1);
    n_cmp++; if (b2.period_valid !== 1'b1 || b2.overflow !== 1'b1)
      begin n_bad++; $display("FAIL ovf_sticky: got v%0b ovf%0b want 1 1", b2.period_valid, b2.overflow); end
    b2.sample_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    int npv = 0;
    int first = -1;
    pulse_reset();
    for (int i = 0; i < 872; i++) step1(sine(i), 1'b1);
    n_cmp++; if (b1.locked !== 1'b1) begin n_bad++; $display("FAIL mid_locked: got %0b want 1", b1.locked); end
    b1.sample_in = sine(872);
    b1.sample_en = 1'b1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (b1.period !== 16'd0 || b1.peak !== 8'd0 || b1.trough !== 8'hff ||
        b1.period_valid !== 1'b0 || b1.locked !== 1'b0 || b1.overflow !== 1'b0)
      begin n_bad++; $display("FAIL mid_reset: got p%0d pk%0d tr%0d v%0b lk%0b o%0b want 0 0 255 0 0 0", b1.period, b1.peak, b1.trough, b1.period_valid, b1.locked, b1.overflow); end
    reset = 1'b1;
    for (int i = 873; i < 1300; i++) begin
      step1(sine(i), 1'b1);
      if (b1.period_valid) begin
        npv++;
        if (first < 0) first = i;
      end
    end
    n_cmp++; if (first !== 1283) begin n_bad++; $display("FAIL mid_resume: got %0d want 1283", first); end
    n_cmp++; if (npv !== 1) begin n_bad++; $display("FAIL mid_count: got %0d want 1", npv); end
  endtask

  task automatic test_threshold();
    pulse_reset();
    step1(8'd0, 1'b1);
    step1(8'd135, 1'b1);
    n_cmp++; if (u1.state !== 2'd1) begin n_bad++; $display("FAIL th_below: got state %0d want 1", u1.state); end
    step1(8'd136, 1'b1);
    n_cmp++; if (b1.period_valid !== 1'b0) begin n_bad++; $display("FAIL th_first: got %0b want 0", b1.period_valid); end
    step1(8'd0, 1'b1);
    step1(8'd135, 1'b1);
    n_cmp++; if (b1.period_valid !== 1'b0) begin n_bad++; $display("FAIL th_135: got %0b want 0", b1.period_valid); end
    step1(8'd136, 1'b1);
    n_cmp++; if (b1.period_valid !== 1'b1 || b1.period !== 16'd3)
      begin n_bad++; $display("FAIL th_136: got v%0b p%0d want 1 3", b1.period_valid, b1.period); end
    n_cmp++; if (b1.peak !== 8'd136 || b1.trough !== 8'd0)
      begin n_bad++; $display("FAIL th_extrema: got pk%0d tr%0d want 136 0", b1.peak, b1.trough); end
    step1(8'd140, 1'b1);
    n_cmp++; if (b1.period_valid !== 1'b0 || b1.period !== 16'd3)
      begin n_bad++; $display("FAIL th_pulse_width: got v%0b p%0d want 0 3", b1.period_valid, b1.period); end
  endtask

  initial begin
    b1.sample_in = '0;
    b1.sample_en = 1'b0;
    b2.sample_in = '0;
    b2.sample_en = 1'b0;
    #2;
    test_reset();
    test_sweep();
    test_noise();
    test_strobe();
    test_overflow();
    test_reset_mid();
    test_threshold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
